// File: rtl/rv32_pipe_pkg.sv
// Shared encodings for the RV32I pipeline hazard logic.
// Forward-select codes, hazard FSM states and the operand-forward rule.
package rv32_pipe_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_WAIT = 2'd1,
      ST_ERR  = 2'd2
   } hz_state_t;

   // MEM beats WB because it holds the younger write to the same register.
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] rs,
      input logic       wr_m,
      input logic [4:0] rd_m,
      input logic       wr_w,
      input logic [4:0] rd_w
   );
      if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
         return FWD_MEM;
      else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_forward_unit.sv
// EX operand bypass select; purely combinational, 0 cycles latency,
// no flow control (evaluated every cycle in every hazard state).
module hazard_forward_unit
   import rv32_pipe_pkg::*;
(
   input  logic [4:0] rs1_E,
   input  logic [4:0] rs2_E,
   input  logic [4:0] rd_M,
   input  logic       regWrite_M,
   input  logic [4:0] rd_W,
   input  logic       regWrite_W,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE
);

   assign ForwardAE = fwd_sel(rs1_E, regWrite_M, rd_M, regWrite_W, rd_W);
   assign ForwardBE = fwd_sel(rs2_E, regWrite_M, rd_M, regWrite_W, rd_W);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard scheduler: stall/flush/forward outputs are combinational (0 latency);
// a dmem wait stalls the whole front end, and a wait of MAX_WAIT cycles locks it up until reset.
module pipeline_hazard_ctrl
   import rv32_pipe_pkg::*;
#(
   parameter int MAX_WAIT = 16,
   parameter int CNT_W    = 16
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       rs1_D,
   input  logic [4:0]       rs2_D,
   input  logic [4:0]       rs1_E,
   input  logic [4:0]       rs2_E,
   input  logic [4:0]       rd_E,
   input  logic             memRead_E,
   input  logic [4:0]       rd_M,
   input  logic [4:0]       rd_W,
   input  logic             regWrite_M,
   input  logic             regWrite_W,
   input  logic             redirect_E,
   input  logic             dmem_req_M,
   input  logic             dmem_ready_M,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             err_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int WCW = $clog2(MAX_WAIT + 1);

   hz_state_t      state;
   logic [WCW-1:0] wait_cnt;
   logic           mem_wait;
   logic           lu;

   assign mem_wait = dmem_req_M & ~dmem_ready_M;
   assign lu       = memRead_E & (rd_E != 5'd0) & ((rd_E == rs1_D) | (rd_E == rs2_D));

   hazard_forward_unit u_fwd (
      .rs1_E      (rs1_E),
      .rs2_E      (rs2_E),
      .rd_M       (rd_M),
      .regWrite_M (regWrite_M),
      .rd_W       (rd_W),
      .regWrite_W (regWrite_W),
      .ForwardAE  (ForwardAE),
      .ForwardBE  (ForwardBE)
   );

   // Stalling everything during a wait keeps a pending redirect parked in EX.
   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      if ((state == ST_ERR) || mem_wait) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
      end else if (redirect_E) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
      end else if (lu) begin
         StallF = 1'b1;
         StallD = 1'b1;
         FlushE = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_RUN;
         wait_cnt    <= '0;
         err_timeout <= 1'b0;
         stall_cnt   <= '0;
         flush_cnt   <= '0;
      end else begin
         if (StallF && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if ((FlushD | FlushE) && (flush_cnt != {CNT_W{1'b1}}))
            flush_cnt <= flush_cnt + CNT_W'(1);

         case (state)
            ST_RUN: begin
               if (mem_wait) begin
                  wait_cnt <= WCW'(1);
                  if (MAX_WAIT <= 1) begin
                     state       <= ST_ERR;
                     err_timeout <= 1'b1;
                  end else begin
                     state <= ST_WAIT;
                  end
               end
            end
            // A dropped request ends the wait just like a ready does.
            ST_WAIT: begin
               if (!mem_wait) begin
                  state    <= ST_RUN;
                  wait_cnt <= '0;
               end else begin
                  wait_cnt <= wait_cnt + WCW'(1);
                  if (wait_cnt == WCW'(MAX_WAIT - 1)) begin
                     state       <= ST_ERR;
                     err_timeout <= 1'b1;
                  end
               end
            end
            default: state <= ST_ERR;
         endcase
      end
   end

endmodule
